// File: rtl/expr_eval_if.sv
// expr_eval_if: character-stream bus between a producer and the expression
// evaluator.
//   in        8-bit ASCII character (producer -> evaluator)
//   in_valid  qualifies in, one character per cycle (producer -> evaluator)
//   result    value of the expression received so far (evaluator -> producer)
//   ok        prefix so far is a complete valid expression (evaluator -> producer)
//   err       sticky syntax-error flag (evaluator -> producer)
interface expr_eval_if #(
    parameter int WIDTH = 16
) ();
    logic [7:0]       in;
    logic             in_valid;
    logic [WIDTH-1:0] result;
    logic             ok;
    logic             err;

    modport master (
        output in,
        output in_valid,
        input  result,
        input  ok,
        input  err
    );

    modport slave (
        input  in,
        input  in_valid,
        output result,
        output ok,
        output err
    );
endinterface

// File: rtl/expr_eval.sv
// expr_eval: evaluates an ASCII stream of the form digit (('+'|'*') digit)*
// with '*' binding tighter than '+'. All arithmetic wraps modulo 2^WIDTH.
//   clk  rising-edge clock
//   clr  synchronous active-high reset; discards the character presented with it
//   bus  expr_eval_if slave: in/in_valid in, result/ok/err out (all registered)
module expr_eval #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        clr,
    expr_eval_if.slave  bus
);

    typedef enum logic [1:0] {
        EXP_DIGIT = 2'd0,
        EXP_OP    = 2'd1,
        ERROR     = 2'd2
    } state_t;

    state_t           state_r,  state_nxt_s;
    logic [WIDTH-1:0] sum_r,    sum_nxt_s;
    logic [WIDTH-1:0] term_r,   term_nxt_s;
    logic             mul_r,    mul_nxt_s;
    logic [WIDTH-1:0] result_r, result_nxt_s;
    logic             ok_r;
    logic             err_r,    err_nxt_s;

    logic             is_digit_s;
    logic             is_plus_s;
    logic             is_star_s;
    logic [7:0]       digit_val_s;
    logic [WIDTH-1:0] digit_ext_s;
    logic [WIDTH-1:0] term_new_s;

    // Character classification and the candidate new term for a digit.
    always_comb begin
        is_digit_s  = (bus.in >= 8'd48) && (bus.in <= 8'd57);
        is_plus_s   = (bus.in == 8'd43);
        is_star_s   = (bus.in == 8'd42);
        digit_val_s = bus.in - 8'd48;
        digit_ext_s = {{(WIDTH-8){1'b0}}, digit_val_s};
        // A pending '*' extends the current product; otherwise the digit starts a new term.
        if (mul_r) begin
            term_new_s = term_r * digit_ext_s;
        end else begin
            term_new_s = digit_ext_s;
        end
    end

    // Next-state and datapath update for one consumed character.
    always_comb begin
        state_nxt_s  = state_r;
        sum_nxt_s    = sum_r;
        term_nxt_s   = term_r;
        mul_nxt_s    = mul_r;
        result_nxt_s = result_r;
        err_nxt_s    = err_r;
        if (bus.in_valid) begin
            case (state_r)
                EXP_DIGIT: begin
                    if (is_digit_s) begin
                        state_nxt_s  = EXP_OP;
                        term_nxt_s   = term_new_s;
                        result_nxt_s = sum_r + term_new_s;
                    end else begin
                        state_nxt_s  = ERROR;
                        result_nxt_s = {WIDTH{1'b0}};
                        err_nxt_s    = 1'b1;
                    end
                end
                EXP_OP: begin
                    if (is_plus_s) begin
                        // Close the current term; result already includes it.
                        state_nxt_s = EXP_DIGIT;
                        sum_nxt_s   = sum_r + term_r;
                        mul_nxt_s   = 1'b0;
                    end else if (is_star_s) begin
                        state_nxt_s = EXP_DIGIT;
                        mul_nxt_s   = 1'b1;
                    end else begin
                        state_nxt_s  = ERROR;
                        result_nxt_s = {WIDTH{1'b0}};
                        err_nxt_s    = 1'b1;
                    end
                end
                ERROR: begin
                    // Absorbing: everything after a syntax error is ignored.
                    state_nxt_s = ERROR;
                end
                default: begin
                    state_nxt_s  = ERROR;
                    result_nxt_s = {WIDTH{1'b0}};
                    err_nxt_s    = 1'b1;
                end
            endcase
        end else begin
            // Idle cycle: every register holds.
            state_nxt_s = state_r;
        end
    end

    // State, datapath and output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r  <= EXP_DIGIT;
            sum_r    <= {WIDTH{1'b0}};
            term_r   <= {WIDTH{1'b0}};
            mul_r    <= 1'b0;
            result_r <= {WIDTH{1'b0}};
            ok_r     <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            sum_r    <= sum_nxt_s;
            term_r   <= term_nxt_s;
            mul_r    <= mul_nxt_s;
            result_r <= result_nxt_s;
            ok_r     <= (state_nxt_s == EXP_OP);
            err_r    <= err_nxt_s;
        end
    end

    assign bus.result = result_r;
    assign bus.ok     = ok_r;
    assign bus.err    = err_r;

endmodule

// File: doc/expr_eval.md
# expr_eval

Downstream consumer of the character-stream recogniser. Consumes the same 8-bit ASCII stream of the form digit ( ('+' | '*') digit )* and computes its arithmetic value with '*' binding tighter than '+'. Flags when the prefix received so far is a complete valid expression, and latches a sticky error on any syntax violation. Provides the numeric result that the recogniser's accept flag qualifies.

## Interface

Parameters:
- WIDTH, 16, width of result and internal accumulators; all arithmetic is modulo 2^WIDTH

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  synchronous, active-high reset
- in  input  8  ASCII character
- in_valid  input  1  qualifies in; one character consumed per cycle with in_valid=1
- result  output  WIDTH  value of the expression received so far
- ok  output  1  1 = the prefix received so far is a complete valid expression
- err  output  1  sticky syntax-error flag

## Operation

- Character classes:
  - digit: 48..57, value in-48
  - op: 42 '*' or 43 '+'
  - other: anything else
- State machine:
  - EXP_DIGIT (reset state)
    - digit -> EXP_OP
    - op/other -> ERROR
  - EXP_OP
    - op -> EXP_DIGIT
    - digit/other -> ERROR
  - ERROR: absorbing; left only by clr
- Internal registers: sum (completed terms), term (current product), mul (pending operator is '*').
- On an accepted digit d:
  - if mul=1: term <= term*d, truncated to WIDTH
  - otherwise: term <= d
  - result <= sum + term_new, truncated to WIDTH
- On '+': sum <= sum + term, mul <= 0; result holds.
- On '*': mul <= 1; sum and term hold; result holds.
- Entering ERROR: result <= 0, err <= 1, ok <= 0. All later characters are ignored.
- ok = 1 exactly when the state is EXP_OP. It is registered alongside state.
- in_valid=0: all registers hold.

## Timing

- All outputs are registered. A character sampled at edge N is reflected in result, ok and err after edge N (one-cycle latency).
- Reset values, after a rising edge with clr=1: result=0, ok=0, err=0, sum=0, term=0, mul=0, state EXP_DIGIT.
- clr has priority over in_valid on the same edge; the character presented with clr is discarded.
- clr mid-expression fully restarts parsing. The next valid character is treated as the first.
- Back-to-back characters are accepted every cycle; there is no backpressure.
- Overflow wraps silently. There is no overflow flag, and wrap does not set err.
- The first character being an op sets err on that edge.
- A trailing op gives ok=0 with result holding the last complete value. This is not an error unless a non-digit follows.

## Test plan

- "1+2*3", one char per cycle: after the last edge result=7, ok=1, err=0. After the '*' edge: ok=0, result=3.
- "2*3*4+5" with idle cycles (in_valid=0) inserted between every character: final result=29, ok=1; outputs unchanged across idle cycles.
- "12", then "+": err=1 and result=0 after the '2' edge; err stays 1 and result 0 after '+' and any later input.
- WIDTH=8, "9*9*9*9*9": result=169 (59049 mod 256), ok=1, err=0.
- "7+8", then clr asserted on the same edge as in_valid=1 with '5': result=0, ok=0, err=0. Then "4": result=4, ok=1.
- "+" as the first character: err=1, ok=0, result=0. Then clr, then "0*5+0": result=0, ok=1.
